// File: rtl/spi_load_ctrl.sv
// Serial loader that writes 12-bit SPI frames (8-bit data + 4-bit address) into
// the I or D memory. Optional readback of D memory over miso when SPI_READBACK_EN is defined.
module spi_load_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       csi_n_in,
  input  logic       csd_n_in,
  input  logic       mosi_in,
  input  logic       proc_busy_in,
  input  logic [7:0] rd_data_in,
  output logic       wr_en_out,
  output logic       wr_icache_out,
  output logic       wr_dcache_out,
  output logic [3:0] wr_addr_out,
  output logic [7:0] wr_data_out,
  output logic [3:0] rd_addr_out,
  output logic       miso_out,
  output logic       busy_out,
  output logic       frame_err_out
);

  localparam logic [1:0] SEL_RD   = 2'b00;
  localparam logic [1:0] SEL_I    = 2'b01;
  localparam logic [1:0] SEL_D    = 2'b10;
  localparam logic [1:0] SEL_NONE = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SHIFT  = 3'd1,
    ST_COMMIT = 3'd2,
`ifdef SPI_READBACK_EN
    ST_DRAIN  = 3'd3,
    ST_SEND   = 3'd4
`else
    ST_DRAIN  = 3'd3
`endif
  } state_t;

  state_t      state_r, state_s;
  logic [1:0]  sel_s, tgt_r, tgt_s;
  logic [11:0] sreg_r, sreg_s;
  logic [3:0]  cnt_r, cnt_s;
  logic        err_r, err_s;
  logic        wr_en_r, wr_en_s;
  logic        wr_icache_r, wr_icache_s;
  logic        wr_dcache_r, wr_dcache_s;
  logic [3:0]  wr_addr_r, wr_addr_s;
  logic [7:0]  wr_data_r, wr_data_s;
  logic        busy_r;
  logic        code_ok_s;

  assign sel_s = {csi_n_in, csd_n_in};

`ifdef SPI_READBACK_EN
  logic [3:0] rd_addr_r, rd_addr_s;
  logic       miso_r, miso_s;
  assign code_ok_s   = 1'b1;
  assign rd_addr_out = rd_addr_r;
  assign miso_out    = miso_r;
`else
  logic unused_rd_s;
  assign unused_rd_s = ^rd_data_in;
  // A read request cannot be served in this build, so it is rejected like a busy start.
  assign code_ok_s   = (sel_s != SEL_RD);
  assign rd_addr_out = 4'd0;
  assign miso_out    = 1'b0;
`endif

  // Next-state and next-output logic for the frame FSM.
  always_comb begin
    state_s     = state_r;
    tgt_s       = tgt_r;
    sreg_s      = sreg_r;
    cnt_s       = cnt_r;
    err_s       = err_r;
    wr_en_s     = 1'b0;
    wr_icache_s = 1'b0;
    wr_dcache_s = 1'b0;
    wr_addr_s   = wr_addr_r;
    wr_data_s   = wr_data_r;
`ifdef SPI_READBACK_EN
    rd_addr_s   = rd_addr_r;
    miso_s      = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        if (sel_s == SEL_NONE) begin
          state_s = ST_IDLE;
        end else if (proc_busy_in || !code_ok_s) begin
          err_s   = 1'b1;
          state_s = ST_DRAIN;
        end else begin
          tgt_s   = sel_s;
          sreg_s  = {11'd0, mosi_in};
          cnt_s   = 4'd1;
          err_s   = 1'b0;
          state_s = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (sel_s == SEL_NONE) begin
          if (cnt_r == 4'd12) begin
            // Write strobe is launched here so it is visible during COMMIT.
            wr_en_s     = 1'b1;
            wr_icache_s = (tgt_r == SEL_I);
            wr_dcache_s = (tgt_r == SEL_D);
            wr_addr_s   = sreg_r[3:0];
            wr_data_s   = sreg_r[11:4];
            state_s     = ST_COMMIT;
          end else begin
            err_s   = 1'b1;
            state_s = ST_IDLE;
          end
        end else if (sel_s != tgt_r) begin
          err_s   = 1'b1;
          state_s = ST_DRAIN;
        end else if (cnt_r == 4'd12) begin
          err_s   = 1'b1;
          state_s = ST_DRAIN;
        end else begin
          sreg_s = {sreg_r[10:0], mosi_in};
          cnt_s  = cnt_r + 4'd1;
`ifdef SPI_READBACK_EN
          if ((tgt_r == SEL_RD) && (cnt_r == 4'd3)) begin
            rd_addr_s = {sreg_r[2:0], mosi_in};
            cnt_s     = 4'd0;
            state_s   = ST_SEND;
          end else begin
            state_s = ST_SHIFT;
          end
`else
          state_s = ST_SHIFT;
`endif
        end
      end
      ST_COMMIT: begin
        state_s = ST_IDLE;
      end
      ST_DRAIN: begin
        if (sel_s == SEL_NONE) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
`ifdef SPI_READBACK_EN
      ST_SEND: begin
        if (sel_s == SEL_NONE) begin
          state_s = ST_IDLE;
        end else if (sel_s != tgt_r) begin
          err_s   = 1'b1;
          state_s = ST_DRAIN;
        end else if (cnt_r == 4'd0) begin
          // First SEND cycle: read data for rd_addr_out is valid now.
          miso_s = rd_data_in[7];
          sreg_s = {4'd0, rd_data_in[6:0], 1'b0};
          cnt_s  = 4'd1;
        end else if (cnt_r < 4'd8) begin
          miso_s = sreg_r[7];
          sreg_s = {4'd0, sreg_r[6:0], 1'b0};
          cnt_s  = cnt_r + 4'd1;
        end else begin
          miso_s = 1'b0;
        end
      end
`endif
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      tgt_r       <= SEL_NONE;
      sreg_r      <= 12'd0;
      cnt_r       <= 4'd0;
      err_r       <= 1'b0;
      wr_en_r     <= 1'b0;
      wr_icache_r <= 1'b0;
      wr_dcache_r <= 1'b0;
      wr_addr_r   <= 4'd0;
      wr_data_r   <= 8'd0;
      busy_r      <= 1'b0;
`ifdef SPI_READBACK_EN
      rd_addr_r   <= 4'd0;
      miso_r      <= 1'b0;
`endif
    end else begin
      tgt_r       <= tgt_s;
      sreg_r      <= sreg_s;
      cnt_r       <= cnt_s;
      err_r       <= err_s;
      wr_en_r     <= wr_en_s;
      wr_icache_r <= wr_icache_s;
      wr_dcache_r <= wr_dcache_s;
      wr_addr_r   <= wr_addr_s;
      wr_data_r   <= wr_data_s;
      busy_r      <= (state_s != ST_IDLE);
`ifdef SPI_READBACK_EN
      rd_addr_r   <= rd_addr_s;
      miso_r      <= miso_s;
`endif
    end
  end

  assign wr_en_out     = wr_en_r;
  assign wr_icache_out = wr_icache_r;
  assign wr_dcache_out = wr_dcache_r;
  assign wr_addr_out   = wr_addr_r;
  assign wr_data_out   = wr_data_r;
  assign busy_out      = busy_r;
  assign frame_err_out = err_r;

endmodule

// File: tb/tb_spi_load_ctrl.sv
// Directed self-checking bench for spi_load_ctrl; readback vectors are used
// when SPI_READBACK_EN is defined, otherwise the read select is checked as an error.
module tb_spi_load_ctrl;

  logic       clk;
  logic       rst;
  logic       csi_n_in;
  logic       csd_n_in;
  logic       mosi_in;
  logic       proc_busy_in;
  logic [7:0] rd_data_in;
  logic       wr_en_out;
  logic       wr_icache_out;
  logic       wr_dcache_out;
  logic [3:0] wr_addr_out;
  logic [7:0] wr_data_out;
  logic [3:0] rd_addr_out;
  logic       miso_out;
  logic       busy_out;
  logic       frame_err_out;

  int check_cnt = 0;
  int fail_cnt  = 0;
  int wr_cnt    = 0;

  spi_load_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .csi_n_in      (csi_n_in),
    .csd_n_in      (csd_n_in),
    .mosi_in       (mosi_in),
    .proc_busy_in  (proc_busy_in),
    .rd_data_in    (rd_data_in),
    .wr_en_out     (wr_en_out),
    .wr_icache_out (wr_icache_out),
    .wr_dcache_out (wr_dcache_out),
    .wr_addr_out   (wr_addr_out),
    .wr_data_out   (wr_data_out),
    .rd_addr_out   (rd_addr_out),
    .miso_out      (miso_out),
    .busy_out      (busy_out),
    .frame_err_out (frame_err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count write pulses a little after each active edge.
  always @(posedge clk) begin
    #2;
    if (wr_en_out) wr_cnt++;
  end

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    check_cnt++;
    if (obs !== exp_v) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Drive one cycle of inputs, let the rising edge sample them, return at the next falling edge.
  task automatic step(input logic csi, input logic csd, input logic mosi);
    csi_n_in = csi;
    csd_n_in = csd;
    mosi_in  = mosi;
    @(negedge clk);
  endtask

  // Shift the top n bits of a 12-bit frame, MSB first.
  task automatic send_frame(input logic csi, input logic csd, input logic [11:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      step(csi, csd, bits[11-i]);
    end
  endtask

  initial begin
    int wr_before;
    logic [7:0] rd_pat;

    rst = 1'b1; csi_n_in = 1'b1; csd_n_in = 1'b1; mosi_in = 1'b0;
    proc_busy_in = 1'b0; rd_data_in = 8'hC3;
    @(negedge clk);
    step(1'b1, 1'b1, 1'b0);
    check_value("rst_wr_en", wr_en_out, 0);
    check_value("rst_busy", busy_out, 0);
    check_value("rst_err", frame_err_out, 0);
    check_value("rst_addr", wr_addr_out, 0);
    check_value("rst_data", wr_data_out, 0);
    check_value("rst_miso", miso_out, 0);
    check_value("rst_rd_addr", rd_addr_out, 0);
    rst = 1'b0;
    step(1'b1, 1'b1, 1'b0);

    // D-write 0xA5 @ 3
    send_frame(1'b1, 1'b0, {8'hA5, 4'h3}, 1);
    check_value("d_busy_shift", busy_out, 1);
    send_frame(1'b1, 1'b0, {8'hA5, 4'h3} << 1, 11);
    check_value("d_no_early_wr", wr_en_out, 0);
    step(1'b1, 1'b1, 1'b0);
    check_value("d_wr_en", wr_en_out, 1);
    check_value("d_dcache", wr_dcache_out, 1);
    check_value("d_icache", wr_icache_out, 0);
    check_value("d_addr", wr_addr_out, 4'h3);
    check_value("d_data", wr_data_out, 8'hA5);
    step(1'b1, 1'b1, 1'b0);
    check_value("d_pulse_end", wr_en_out, 0);
    check_value("d_dcache_low", wr_dcache_out, 0);
    check_value("d_addr_hold", wr_addr_out, 4'h3);
    check_value("d_data_hold", wr_data_out, 8'hA5);
    check_value("d_busy_idle", busy_out, 0);

    // I-write 0x7F @ F
    send_frame(1'b0, 1'b1, {8'h7F, 4'hF}, 12);
    step(1'b1, 1'b1, 1'b0);
    check_value("i_wr_en", wr_en_out, 1);
    check_value("i_icache", wr_icache_out, 1);
    check_value("i_dcache", wr_dcache_out, 0);
    check_value("i_addr", wr_addr_out, 4'hF);
    check_value("i_data", wr_data_out, 8'h7F);
    step(1'b1, 1'b1, 1'b0);
    check_value("i_pulse_end", wr_en_out, 0);
    check_value("i_busy_idle", busy_out, 0);
    check_value("wr_count_2", wr_cnt, 2);

    // Short frame (11 bits) sets a sticky error, then a valid frame clears it
    send_frame(1'b1, 1'b0, 12'hFFF, 11);
    step(1'b1, 1'b1, 1'b0);
    check_value("short_err", frame_err_out, 1);
    check_value("short_no_wr", wr_en_out, 0);
    check_value("short_busy", busy_out, 0);
    step(1'b1, 1'b1, 1'b0);
    check_value("short_err_sticky", frame_err_out, 1);
    check_value("short_wr_count", wr_cnt, 2);
    send_frame(1'b1, 1'b0, {8'h3C, 4'h9}, 12);
    check_value("restart_err_clr", frame_err_out, 0);
    step(1'b1, 1'b1, 1'b0);
    check_value("restart_data", wr_data_out, 8'h3C);
    check_value("restart_addr", wr_addr_out, 4'h9);
    step(1'b1, 1'b1, 1'b0);

    // Busy reject at frame start
    proc_busy_in = 1'b1;
    send_frame(1'b1, 1'b0, {8'h11, 4'h2}, 1);
    proc_busy_in = 1'b0;
    check_value("bsy_err", frame_err_out, 1);
    check_value("bsy_drain", busy_out, 1);
    send_frame(1'b1, 1'b0, {8'h11, 4'h2} << 1, 11);
    step(1'b1, 1'b1, 1'b0);
    check_value("bsy_idle", busy_out, 0);
    step(1'b1, 1'b1, 1'b0);
    check_value("bsy_no_wr", wr_cnt, 3);
    check_value("bsy_err_sticky", frame_err_out, 1);

    // proc_busy_in rising mid-frame does not abort
    send_frame(1'b0, 1'b1, {8'h5A, 4'h6}, 3);
    proc_busy_in = 1'b1;
    send_frame(1'b0, 1'b1, {8'h5A, 4'h6} << 3, 9);
    step(1'b1, 1'b1, 1'b0);
    check_value("mid_bsy_wr", wr_en_out, 1);
    check_value("mid_bsy_data", wr_data_out, 8'h5A);
    check_value("mid_bsy_err", frame_err_out, 0);
    proc_busy_in = 1'b0;
    step(1'b1, 1'b1, 1'b0);

    // 13th bit -> error, drain, no write
    wr_before = wr_cnt;
    send_frame(1'b1, 1'b0, 12'h0F0, 12);
    step(1'b1, 1'b0, 1'b1);
    check_value("long_err", frame_err_out, 1);
    check_value("long_drain", busy_out, 1);
    step(1'b1, 1'b1, 1'b0);
    check_value("long_idle", busy_out, 0);
    step(1'b1, 1'b1, 1'b0);
    check_value("long_no_wr", wr_cnt, wr_before);

    // Select switches D -> I mid-frame
    send_frame(1'b1, 1'b0, 12'hABC, 4);
    step(1'b0, 1'b1, 1'b0);
    check_value("swap_err", frame_err_out, 1);
    check_value("swap_drain", busy_out, 1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check_value("swap_no_wr", wr_cnt, wr_before);

    // Reset after 6 bits
    send_frame(1'b1, 1'b0, 12'hFFF, 6);
    rst = 1'b1;
    step(1'b1, 1'b0, 1'b1);
    check_value("rmid_busy", busy_out, 0);
    check_value("rmid_err", frame_err_out, 0);
    check_value("rmid_addr", wr_addr_out, 0);
    check_value("rmid_data", wr_data_out, 0);
    rst = 1'b0;
    step(1'b1, 1'b1, 1'b0);
    check_value("rmid_no_wr", wr_en_out, 0);
    check_value("rmid_idle", busy_out, 0);
    step(1'b1, 1'b1, 1'b0);
    check_value("rmid_wr_count", wr_cnt, wr_before);

    // Reset on the deselect edge suppresses the pending write
    send_frame(1'b1, 1'b0, {8'hEE, 4'h7}, 12);
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    check_value("rcommit_no_wr", wr_en_out, 0);
    check_value("rcommit_data", wr_data_out, 0);
    rst = 1'b0;
    step(1'b1, 1'b1, 1'b0);
    check_value("rcommit_still_no_wr", wr_en_out, 0);

`ifdef SPI_READBACK_EN
    // Readback of address 5, memory returns 0xC3
    rd_data_in = 8'hC3;
    rd_pat     = 8'hC3;
    send_frame(1'b0, 1'b0, {4'h5, 8'h00}, 4);
    check_value("rb_rd_addr", rd_addr_out, 4'h5);
    check_value("rb_busy", busy_out, 1);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b0);
      check_value($sformatf("rb_miso_%0d", i), miso_out, rd_pat[7-i]);
    end
    step(1'b0, 1'b0, 1'b0);
    check_value("rb_miso_past", miso_out, 0);
    check_value("rb_err", frame_err_out, 0);
    step(1'b1, 1'b1, 1'b0);
    check_value("rb_idle", busy_out, 0);
    check_value("rb_miso_idle", miso_out, 0);
`else
    // Read select is an error in this build
    rd_pat = 8'h00;
    send_frame(1'b0, 1'b0, {4'h5, 8'h00}, 4);
    check_value("rd_off_err", frame_err_out, 1);
    check_value("rd_off_drain", busy_out, 1);
    check_value("rd_off_miso", miso_out, rd_pat[7]);
    check_value("rd_off_addr", rd_addr_out, 0);
    step(1'b1, 1'b1, 1'b0);
    check_value("rd_off_idle", busy_out, 0);
`endif
    step(1'b1, 1'b1, 1'b0);
    check_value("final_wr_count", wr_cnt, wr_before);

    $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/spi_load_ctrl.md
SPI_LOAD_CTRL -- requirements
Module: spi_load_ctrl

Interface
REQ-001 SHALL have ports: clk input 1 (single clock, all state on rising edge); rst input 1 (synchronous, active-high reset).
REQ-002 SHALL have ports: csi_n_in input 1 (instruction-memory select, active-low); csd_n_in input 1 (data-memory select, active-low); mosi_in input 1 (serial data, one bit per clk).
REQ-003 SHALL have ports: proc_busy_in input 1 (processor executing); rd_data_in input 8 (data-memory read data for the address on rd_addr_out).
REQ-004 SHALL have ports: wr_en_out output 1; wr_icache_out output 1; wr_dcache_out output 1; wr_addr_out output 4; wr_data_out output 8.
REQ-005 SHALL have ports: rd_addr_out output 4; miso_out output 1; busy_out output 1 (state != IDLE); frame_err_out output 1 (sticky error flag).

Function
REQ-006 SHALL implement states IDLE, SHIFT, COMMIT, DRAIN, and (macro only) SEND.
REQ-007 Select code: {csi_n_in,csd_n_in} = 01 -> I-target; 10 -> D-target; 00 -> READ-target; 11 -> deselected.
REQ-008 IDLE, select code != 11, proc_busy_in=0: SHALL latch target, shift mosi_in as first bit, set bit count to 1, clear frame_err_out, go SHIFT.
REQ-009 IDLE, select code != 11, proc_busy_in=1: SHALL set frame_err_out, go DRAIN with no shift and no write.
REQ-010 SHIFT: every cycle the select code equals the latched code SHALL shift mosi_in in MSB-first and increment the 4-bit count.
REQ-011 A 12-bit frame SHALL be interpreted as bits[11:4]=data, bits[3:0]=address; the first received bit is data bit 7.
REQ-012 SHIFT, select code becomes 11 with count=12: SHALL go COMMIT.
REQ-013 SHIFT, select code becomes 11 with count!=12: SHALL set frame_err_out, go IDLE, no write.
REQ-014 SHIFT, count=12 and select still asserted (13th bit): SHALL set frame_err_out, go DRAIN, no write.
REQ-015 SHIFT, select code changes to a different asserted code: SHALL set frame_err_out, go DRAIN.
REQ-016 COMMIT: SHALL assert wr_en_out for exactly one cycle, with wr_icache_out/wr_dcache_out per target and wr_addr_out/wr_data_out from the frame, then go IDLE.
REQ-017 Write latency SHALL be exactly one cycle after the first cycle the select code is observed 11.
REQ-018 wr_icache_out and wr_dcache_out SHALL be 0 whenever wr_en_out=0; wr_addr_out and wr_data_out SHALL hold their last committed values.
REQ-019 DRAIN: SHALL ignore mosi_in and return to IDLE on the first cycle the select code is 11.
REQ-020 proc_busy_in SHALL be sampled only at frame start; a change mid-frame SHALL NOT abort the frame.
REQ-021 frame_err_out SHALL stay set until the next accepted frame start (REQ-008) or reset.

Reset
REQ-022 rst=1 SHALL force IDLE at the next clk edge, from any state including mid-frame, discarding partial frames.
REQ-023 Reset values: wr_en_out, wr_icache_out, wr_dcache_out, miso_out, busy_out and frame_err_out = 0; wr_addr_out, wr_data_out and rd_addr_out = 0; bit count = 0.
REQ-024 A write in progress at reset SHALL NOT be issued.

Configuration
REQ-025 Macro SPI_READBACK_EN SHALL gate the readback feature.
REQ-026 With SPI_READBACK_EN: a READ-target frame SHALL shift 4 address bits.
REQ-027 With SPI_READBACK_EN: after the 4th address bit, the block SHALL drive rd_addr_out, go SEND, and capture rd_data_in on the following cycle.
REQ-028 With SPI_READBACK_EN: SEND SHALL present the captured data on miso_out MSB-first, one bit per cycle while selected, for 8 cycles.
REQ-029 With SPI_READBACK_EN: early deselect in SEND is legal (no error); selection beyond 8 bits drives miso_out=0; miso_out=0 outside SEND.
REQ-030 Without SPI_READBACK_EN: select code 00 SHALL be handled as REQ-009 (error, DRAIN); miso_out and rd_addr_out SHALL be tied 0; the SEND state SHALL be absent.

Verification
REQ-031 D-write: csd_n_in low 12 cycles shifting 0xA5 then 0x3, then high -> one cycle later wr_en_out=1, wr_dcache_out=1, wr_addr_out=3, wr_data_out=0xA5.
REQ-032 I-write: csi_n_in low 12 cycles shifting 0x7F then 0xF -> wr_icache_out=1, wr_addr_out=0xF, wr_data_out=0x7F, single-cycle pulse, busy_out returns 0.
REQ-033 Short frame: csd_n_in low 11 cycles -> frame_err_out=1, no wr_en_out. Next valid frame start clears frame_err_out.
REQ-034 Busy reject: proc_busy_in=1 at frame start with a 12-bit frame -> frame_err_out=1, no write, IDLE after deselect.
REQ-035 Reset mid-frame: rst=1 after 6 bits -> IDLE, all outputs 0, no write after deselect.
REQ-036 Readback (SPI_READBACK_EN): both selects low, address 0x5, rd_data_in=0xC3 -> rd_addr_out=5, miso_out sequence 1,1,0,0,0,0,1,1.
